// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer array: register offsets,
// channel stride, TCTL bit positions and the in-channel register decoder.
// The optional interrupt enable bit (TCTL[8]) is built only with TIMER_IRQ_EN.
package timer_pkg;

    localparam logic [3:0] OFF_TCNT  = 4'h0;
    localparam logic [3:0] OFF_TLIM  = 4'h4;
    localparam logic [3:0] OFF_TCTL  = 4'h8;
    localparam int         CH_STRIDE = 16;

    localparam int TCTL_READY   = 0;
    localparam int TCTL_OVF     = 2;
    localparam int TCTL_EN      = 4;
    localparam int TCTL_ONESHOT = 5;
    localparam int TCTL_IE      = 8;

    typedef enum logic [1:0] {
        REG_TCNT = 2'd0,
        REG_TLIM = 2'd1,
        REG_TCTL = 2'd2,
        REG_RSVD = 2'd3
    } reg_sel_e;

    // Map a byte offset inside one channel window to a register; unaligned
    // and reserved offsets fall into REG_RSVD (reads 0, writes ignored).
    function automatic reg_sel_e decode_reg(input logic [3:0] off);
        case (off)
            OFF_TCNT: return REG_TCNT;
            OFF_TLIM: return REG_TLIM;
            OFF_TCTL: return REG_TCTL;
            default:  return REG_RSVD;
        endcase
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TCNT, TLIM, TCTL flags and the terminal-count logic.
// Counts on prescaler ticks while EN is set. Software writes take priority
// over the tick for TCNT/TLIM; hardware READY/OVF set wins over software clear.
// With TIMER_IRQ_EN defined, TCTL[8] IE is implemented and irq is READY & IE,
// registered; otherwise irq is tied low.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_tcnt,
    input  logic             wr_tlim,
    input  logic             wr_tctl,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] tcnt,
    output logic [CNT_W-1:0] tlim,
    output logic [31:0]      tctl,
    output logic             irq
);

    logic [CNT_W-1:0] tcnt_r, tcnt_nxt_s;
    logic [CNT_W-1:0] tlim_r, tlim_nxt_s;
    logic             ready_r, ready_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic             en_r, en_nxt_s;
    logic             oneshot_r, oneshot_nxt_s;
    logic             terminal_s;
    logic             fire_s;
    logic             ie_bit_s;
    logic [31:0]      tctl_s;
    logic             unused_s;

    assign unused_s = ^wdata;

    // Terminal condition: last count before wrap (full range when TLIM is 0)
    always_comb begin
        terminal_s = 1'b0;
        if (tlim_r != {CNT_W{1'b0}}) begin
            terminal_s = (tcnt_r == (tlim_r - CNT_W'(1'b1)));
        end else begin
            terminal_s = (tcnt_r == {CNT_W{1'b1}});
        end
    end

    assign fire_s = tick & en_r & terminal_s;

    // Next-state for counter, limit and control flags with write priorities
    always_comb begin
        tcnt_nxt_s    = tcnt_r;
        tlim_nxt_s    = tlim_r;
        ready_nxt_s   = ready_r;
        ovf_nxt_s     = ovf_r;
        en_nxt_s      = en_r;
        oneshot_nxt_s = oneshot_r;

        if (wr_tlim) begin
            tcnt_nxt_s = {CNT_W{1'b0}};
        end else if (wr_tcnt) begin
            tcnt_nxt_s = wdata[CNT_W-1:0];
        end else if (fire_s) begin
            tcnt_nxt_s = {CNT_W{1'b0}};
        end else if (tick && en_r) begin
            tcnt_nxt_s = tcnt_r + CNT_W'(1'b1);
        end else begin
            tcnt_nxt_s = tcnt_r;
        end

        if (wr_tlim) begin
            tlim_nxt_s = wdata[CNT_W-1:0];
        end else begin
            tlim_nxt_s = tlim_r;
        end

        if (fire_s && ready_r) begin
            ovf_nxt_s = 1'b1;
        end else if (wr_tctl && !wdata[TCTL_OVF]) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        if (fire_s) begin
            ready_nxt_s = 1'b1;
        end else if (wr_tctl && !wdata[TCTL_READY]) begin
            ready_nxt_s = 1'b0;
        end else begin
            ready_nxt_s = ready_r;
        end

        if (wr_tctl) begin
            en_nxt_s = wdata[TCTL_EN];
        end else if (fire_s && oneshot_r) begin
            en_nxt_s = 1'b0;
        end else begin
            en_nxt_s = en_r;
        end

        if (wr_tctl) begin
            oneshot_nxt_s = wdata[TCTL_ONESHOT];
        end else begin
            oneshot_nxt_s = oneshot_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_r    <= {CNT_W{1'b0}};
            tlim_r    <= {CNT_W{1'b0}};
            ready_r   <= 1'b0;
            ovf_r     <= 1'b0;
            en_r      <= 1'b0;
            oneshot_r <= 1'b0;
        end else begin
            tcnt_r    <= tcnt_nxt_s;
            tlim_r    <= tlim_nxt_s;
            ready_r   <= ready_nxt_s;
            ovf_r     <= ovf_nxt_s;
            en_r      <= en_nxt_s;
            oneshot_r <= oneshot_nxt_s;
        end
    end

`ifdef TIMER_IRQ_EN
    logic ie_r, ie_nxt_s, irq_r;

    // Interrupt enable next-state (plain R/W bit)
    always_comb begin
        ie_nxt_s = ie_r;
        if (wr_tctl) begin
            ie_nxt_s = wdata[TCTL_IE];
        end else begin
            ie_nxt_s = ie_r;
        end
    end

    // Interrupt enable and registered level interrupt request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            ie_r  <= ie_nxt_s;
            irq_r <= ready_r & ie_r;
        end
    end

    assign ie_bit_s = ie_r;
    assign irq      = irq_r;
`else
    assign ie_bit_s = 1'b0;
    assign irq      = 1'b0;
`endif

    // Assemble the TCTL read value; undefined bits read 0
    always_comb begin
        tctl_s               = 32'h0000_0000;
        tctl_s[TCTL_READY]   = ready_r;
        tctl_s[TCTL_OVF]     = ovf_r;
        tctl_s[TCTL_EN]      = en_r;
        tctl_s[TCTL_ONESHOT] = oneshot_r;
        tctl_s[TCTL_IE]      = ie_bit_s;
    end

    assign tcnt = tcnt_r;
    assign tlim = tlim_r;
    assign tctl = tctl_s;

endmodule

// File: rtl/mm_timer_array.sv
// Memory-mapped multi-channel timer. One shared prescaler produces a tick
// every PRESCALE clocks; NUM_CH channels live at BASE_ADDR + 16*c with
// TCNT/TLIM/TCTL at +0/+4/+8. Reads are combinational from abus, writes
// take effect on the clock edge where wren is high.
// Optional macro TIMER_IRQ_EN enables TCTL[8] IE and the irq outputs.
module mm_timer_array
    import timer_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESCALE  = 50000,
    parameter logic [31:0] BASE_ADDR = 32'hF000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       abus,
    input  logic [31:0]       dbus_in,
    input  logic              wren,
    output logic [31:0]       dbus_out,
    output logic [NUM_CH-1:0] irq
);

    localparam int          PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(NUM_CH * CH_STRIDE);

    logic [PS_W-1:0]  presc_r;
    logic             tick_s;
    logic [31:0]      off_s;
    logic             hit_s;
    logic [2:0]       ch_s;
    reg_sel_e         sel_s;
    logic [31:0]      rdata_s;

    logic [CNT_W-1:0] tcnt_a [NUM_CH];
    logic [CNT_W-1:0] tlim_a [NUM_CH];
    logic [31:0]      tctl_a [NUM_CH];

    assign tick_s = (presc_r == PS_W'(PRESCALE - 1));

    // Free-running prescaler, wraps after PRESCALE-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PS_W{1'b0}};
        end else begin
            presc_r <= presc_r + PS_W'(1'b1);
        end
    end

    // Address decode: window hit, channel index and register select
    always_comb begin
        off_s = abus - BASE_ADDR;
        hit_s = (off_s < WIN_BYTES);
        ch_s  = off_s[6:4];
        if (hit_s) begin
            sel_s = decode_reg(off_s[3:0]);
        end else begin
            sel_s = REG_RSVD;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_wr_s;
        assign ch_wr_s = wren & hit_s & (ch_s == 3'(c));

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick_s),
            .wr_tcnt (ch_wr_s & (sel_s == REG_TCNT)),
            .wr_tlim (ch_wr_s & (sel_s == REG_TLIM)),
            .wr_tctl (ch_wr_s & (sel_s == REG_TCTL)),
            .wdata   (dbus_in),
            .tcnt    (tcnt_a[c]),
            .tlim    (tlim_a[c]),
            .tctl    (tctl_a[c]),
            .irq     (irq[c])
        );
    end

    // Read mux: zero-extended register of the addressed channel, else 0
    always_comb begin
        rdata_s = 32'h0000_0000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit_s && (ch_s == 3'(c))) begin
                case (sel_s)
                    REG_TCNT: rdata_s = 32'(tcnt_a[c]);
                    REG_TLIM: rdata_s = 32'(tlim_a[c]);
                    REG_TCTL: rdata_s = tctl_a[c];
                    default:  rdata_s = 32'h0000_0000;
                endcase
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    assign dbus_out = rdata_s;

endmodule

// File: tb/tb_mm_timer_array.sv
// Self-checking bench for mm_timer_array (NUM_CH=2, CNT_W=8, PRESCALE=4).
// A behavioural model tracks ticks by edge count and applies the timer rules;
// every register, irq and an unmapped address are compared after each cycle.
module tb_mm_timer_array;

    localparam int          NCH  = 2;
    localparam int          CW   = 8;
    localparam int          PS   = 4;
    localparam logic [31:0] BASE = 32'hF000_0100;
`ifdef TIMER_IRQ_EN
    localparam bit HAS_IE = 1'b1;
`else
    localparam bit HAS_IE = 1'b0;
`endif

    logic           clk, reset, wren;
    logic [31:0]    abus, dbus_in, dbus_out;
    logic [NCH-1:0] irq;

    int errors = 0;
    int checks = 0;

    int       m_edges;
    logic [7:0] m_cnt [NCH];
    logic [7:0] m_lim [NCH];
    bit       m_rdy [NCH];
    bit       m_ovf [NCH];
    bit       m_en  [NCH];
    bit       m_os  [NCH];
    bit       m_ie  [NCH];
    bit       m_irq [NCH];

    mm_timer_array #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .PRESCALE  (PS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .abus     (abus),
        .dbus_in  (dbus_in),
        .wren     (wren),
        .dbus_out (dbus_out),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic m_reset();
        m_edges = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 8'd0; m_lim[c] = 8'd0;
            m_rdy[c] = 1'b0; m_ovf[c] = 1'b0; m_en[c] = 1'b0;
            m_os[c] = 1'b0;  m_ie[c] = 1'b0;  m_irq[c] = 1'b0;
        end
    endtask

    function automatic bit m_term(input int c);
        if (m_lim[c] != 8'd0) return (int'(m_cnt[c]) + 1 == int'(m_lim[c]));
        return (m_cnt[c] == 8'hFF);
    endfunction

    function automatic bit m_in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32) && (a[1:0] == 2'b00);
    endfunction

    // Apply one clock edge of the timer rules to the model
    task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit tick, hit, fire;
        int ch, rg;
        logic [31:0] off;
        m_edges++;
        tick = (m_edges % PS == 0);
        hit  = we && m_in_window(a);
        off  = a - BASE;
        ch   = int'(off / 32'd16);
        rg   = int'((off % 32'd16) / 32'd4);
        for (int c = 0; c < NCH; c++) begin
            bit wc, wl, wt;
            wc = hit && ch == c && rg == 0;
            wl = hit && ch == c && rg == 1;
            wt = hit && ch == c && rg == 2;
            fire = tick && m_en[c] && m_term(c);
            m_irq[c] = HAS_IE && m_rdy[c] && m_ie[c];
            if (wl) m_cnt[c] = 8'd0;
            else if (wc) m_cnt[c] = d[7:0];
            else if (tick && m_en[c]) m_cnt[c] = fire ? 8'd0 : m_cnt[c] + 8'd1;
            if (wl) m_lim[c] = d[7:0];
            if (fire && m_rdy[c]) m_ovf[c] = 1'b1;
            else if (wt && !d[2]) m_ovf[c] = 1'b0;
            if (fire) m_rdy[c] = 1'b1;
            else if (wt && !d[0]) m_rdy[c] = 1'b0;
            if (wt) m_en[c] = d[4];
            else if (fire && m_os[c]) m_en[c] = 1'b0;
            if (wt) m_os[c] = d[5];
            if (wt && HAS_IE) m_ie[c] = d[8];
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        int ch, rg;
        if (!m_in_window(a)) return 32'h0;
        off = a - BASE;
        ch  = int'(off / 32'd16);
        rg  = int'((off % 32'd16) / 32'd4);
        case (rg)
            0: return {24'h0, m_cnt[ch]};
            1: return {24'h0, m_lim[ch]};
            2: return {23'h0, (HAS_IE && m_ie[ch]), 2'b00, m_os[ch], m_en[ch],
                       1'b0, m_ovf[ch], 1'b0, m_rdy[ch]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] a;
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                a = BASE + 32'(16 * c + 4 * r);
                abus = a;
                #1;
                chk($sformatf("ch%0d_reg%0d", c, r), dbus_out, m_read(a));
            end
        end
        #1;
        chk("irq", {30'h0, irq}, {30'h0, m_irq[1], m_irq[0]});
        a = $urandom;
        if (a >= BASE - 32'd16 && a < BASE + 32'd48) a = 32'h0000_0040;
        abus = a;
        #1;
        chk("unmapped", dbus_out, 32'h0);
    endtask

    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d);
        abus = a; dbus_in = d; wren = we;
        @(posedge clk);
        m_edge(we, a, d);
        #1;
        wren = 1'b0;
        check_all();
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        abus = a;
        #1;
        chk(tag, dbus_out, exp);
    endtask

    initial begin
        bit found;
        reset = 1'b0; wren = 1'b0; abus = 32'h0; dbus_in = 32'h0;
        m_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();

        // ch0 periodic with TLIM=3, several wraps to set READY then OVF
        cyc(1'b1, BASE + 32'h4, 32'd3);
        cyc(1'b1, BASE + 32'h8, 32'h10);
        repeat (28) cyc(1'b0, 32'h0, 32'h0);
        cyc(1'b1, BASE + 32'h8, 32'h10);

        // ch1 one-shot with TLIM=2
        cyc(1'b1, BASE + 32'h14, 32'd2);
        cyc(1'b1, BASE + 32'h18, 32'h30);
        repeat (24) cyc(1'b0, 32'h0, 32'h0);
        read_chk("ch1_oneshot_tctl", BASE + 32'h18, 32'h21);
        read_chk("ch1_oneshot_tcnt", BASE + 32'h10, 32'h0);

        // ch0 full-range wrap with TLIM=0 starting from 0xFE
        cyc(1'b1, BASE + 32'h8, 32'h00);
        cyc(1'b1, BASE + 32'h4, 32'h0);
        cyc(1'b1, BASE + 32'h0, 32'hFE);
        cyc(1'b1, BASE + 32'h8, 32'h10);
        repeat (8) cyc(1'b0, 32'h0, 32'h0);
        read_chk("ch0_wrap_tcnt", BASE + 32'h0, 32'h0);
        read_chk("ch0_wrap_tctl", BASE + 32'h8, 32'h11);

        // READY clear coinciding with a terminal tick: hardware set wins
        cyc(1'b1, BASE + 32'h8, 32'h00);
        cyc(1'b1, BASE + 32'h4, 32'd2);
        cyc(1'b1, BASE + 32'h8, 32'h10);
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (((m_edges + 1) % PS == 0) && m_en[0] && m_term(0)) begin
                found = 1'b1;
                break;
            end
            cyc(1'b0, 32'h0, 32'h0);
        end
        chk("collide_setup", {31'h0, found}, 32'h1);
        cyc(1'b1, BASE + 32'h8, 32'h10);
        abus = BASE + 32'h8;
        #1;
        chk("ready_wins", {31'h0, dbus_out[0]}, 32'h1);

        // TLIM and TCNT writes coinciding with a tick on ch1
        cyc(1'b1, BASE + 32'h18, 32'h00);
        cyc(1'b1, BASE + 32'h14, 32'h0);
        cyc(1'b1, BASE + 32'h10, 32'd5);
        cyc(1'b1, BASE + 32'h18, 32'h10);
        for (int k = 0; k < PS && ((m_edges + 1) % PS != 0); k++) cyc(1'b0, 32'h0, 32'h0);
        cyc(1'b1, BASE + 32'h14, 32'd9);
        read_chk("tlim_tick_tcnt", BASE + 32'h10, 32'h0);
        for (int k = 0; k < PS && ((m_edges + 1) % PS != 0); k++) cyc(1'b0, 32'h0, 32'h0);
        cyc(1'b1, BASE + 32'h10, 32'h40);
        read_chk("tcnt_tick_tcnt", BASE + 32'h10, 32'h40);

        // Randomized register traffic, including reserved and unmapped writes
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d, a;
            int pick, ch, rg;
            d = $urandom;
            pick = $urandom_range(7, 0);
            if (pick < 3) begin
                ch = $urandom_range(2, 0);
                rg = $urandom_range(3, 0);
                a = BASE + 32'(16 * ch + 4 * rg);
                if (rg == 1) d[7:0] = 8'($urandom_range(5, 0));
                if (rg == 2) d[4] = ($urandom_range(3, 0) != 0);
                cyc(1'b1, a, d);
            end else if (pick == 3) begin
                cyc(1'b1, BASE - 32'd4, d);
            end else begin
                a = $urandom;
                cyc(1'b0, a, d);
            end
        end

        // Interrupt path: IE set, TLIM=1, then clear READY
        cyc(1'b1, BASE + 32'h8, 32'h110);
        cyc(1'b1, BASE + 32'h4, 32'd1);
        repeat (10) cyc(1'b0, 32'h0, 32'h0);
        cyc(1'b1, BASE + 32'h8, 32'h100);
        repeat (4) cyc(1'b0, 32'h0, 32'h0);

        // Reset asserted mid-count clears everything immediately
        cyc(1'b1, BASE + 32'h8, 32'h110);
        repeat (5) cyc(1'b0, 32'h0, 32'h0);
        #1;
        reset = 1'b0;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();
        cyc(1'b1, BASE + 32'h4, 32'd2);
        cyc(1'b1, BASE + 32'h8, 32'h10);
        repeat (12) cyc(1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_timer_array.md
Name: mm_timer_array

Overview:
- Memory-mapped, multi-channel timer peripheral on the CPU data bus (abus / dbus_in / dbus_out / wren), beside data memory and the I/O devices.
- Next generation of the single-channel millisecond timer: NUM_CH independent channels, parametrised counter width and prescaler.
- Per-channel enable, one-shot/periodic mode, and sticky ready/overflow flags.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, TCNT/TLIM width in bits (1..32).
- PRESCALE, 50000, clk cycles per timer tick (50 MHz -> 1 kHz); must be >= 1.
- BASE_ADDR, 32'hF0000100, byte address of channel 0; channel stride 16 bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- abus  in  32  byte address from CPU.
- dbus_in  in  32  write data.
- wren  in  1  write strobe, sampled on the rising clk edge.
- dbus_out  out  32  read data, combinational from abus; 32'b0 when abus does not hit a register.
- irq  out  NUM_CH  per-channel interrupt request, level.

Behaviour:
- Register map per channel c (base = BASE_ADDR + 16*c):
  - +0 TCNT
  - +4 TLIM
  - +8 TCTL
  - +C reserved: reads 0, writes ignored.
- Addresses outside the window: dbus_out = 0, no state change. Reads zero-extend CNT_W to 32. Writes use dbus_in[CNT_W-1:0].
- TCTL bit fields:
  - [0] READY, sticky.
  - [2] OVF, sticky.
  - [4] EN.
  - [5] ONESHOT.
  - [8] IE (macro only).
  - All other bits read 0.
  - READY and OVF: writing 0 clears, writing 1 is ignored. EN, ONESHOT, IE: plain R/W.
- Reset (reset = 0, async): prescaler = 0; every TCNT, TLIM, TCTL = 0; irq = 0; dbus_out follows abus and reads zero values.
- Prescaler:
  - One shared counter 0..PRESCALE-1; tick is asserted for one cycle when the counter equals PRESCALE-1, and the counter then wraps to 0.
  - PRESCALE = 1 gives a tick every cycle.
  - The prescaler runs continuously out of reset, independent of channel writes.
- Per channel, on a tick with EN = 1:
  - Terminal condition: (TLIM != 0 and TCNT == TLIM-1), or (TLIM == 0 and TCNT == all-ones).
  - At terminal: TCNT <= 0. If READY is already 1, set OVF. Set READY. If ONESHOT = 1, clear EN.
  - Otherwise TCNT <= TCNT + 1.
  - EN = 0: TCNT holds.
- Writes, same-cycle priority:
  - TCNT write overrides the tick increment/wrap for that channel that cycle; READY/OVF are unaffected by the write.
  - TLIM write loads TLIM and forces TCNT <= 0 that cycle, overriding any tick.
  - TCTL write on a terminal tick: hardware set of READY/OVF wins over software clear. Software EN = 1 wins over the one-shot auto-clear.
- Mid-operation reset: all state returns to reset values immediately, with no pending tick.
- Read latency: 0 cycles (combinational). Write latency: 1 cycle (visible on the next read after the edge).

Optional Feature:
- Macro TIMER_IRQ_EN.
- Defined: TCTL[8] IE is implemented (R/W), and irq[c] = READY[c] & IE[c], registered (asserts 1 cycle after READY sets; deasserts 1 cycle after READY or IE clears).
- Undefined: TCTL[8] reads 0 and writes are ignored; irq is tied to 0.

Decomposition:
- Package timer_pkg:
  - Register offsets: OFF_TCNT = 0, OFF_TLIM = 4, OFF_TCTL = 8.
  - Channel stride: 16.
  - TCTL bit indices: READY = 0, OVF = 2, EN = 4, ONESHOT = 5, IE = 8.
- Sub-module timer_channel (parameter CNT_W):
  - Holds TCNT, TLIM, TCTL and the terminal logic for one channel.
  - Inputs: tick, per-channel write decode.
- Top level: prescaler, address decode, generate loop over NUM_CH, read mux.

Test Plan (PRESCALE = 4, CNT_W = 8, NUM_CH = 2):
- Reset released, read ch0/ch1 TCNT/TLIM/TCTL -> all 0; irq = 0; non-mapped address reads 0.
- ch0 TLIM = 3, TCTL = 0x10 -> TCNT reads 0,1,2 at 4-cycle intervals. On the 3rd tick TCNT = 0 and TCTL = 0x11. On the 6th tick TCTL = 0x15 (OVF). Write TCTL = 0x10 -> 0x10.
- ch1 TLIM = 2, TCTL = 0x30 (one-shot) -> after the 2nd tick TCTL = 0x21, TCNT stays 0 on later ticks. ch0 counts unaffected throughout.
- ch0 TLIM = 0, TCNT written 0xFE, EN = 1 -> next tick TCNT = 0xFF; following tick TCNT = 0 and READY = 1.
- Write TCTL = 0x10 (clear READY) in the same cycle as the terminal tick -> READY = 1 afterwards. A TLIM write coinciding with a tick -> TCNT = 0.
- TIMER_IRQ_EN defined: TCTL = 0x110, TLIM = 1 -> irq[0] = 1 one cycle after READY sets; clear READY -> irq[0] = 0 one cycle later. Assert reset mid-count -> all registers 0 immediately.
